term_ctrl: RTL
==============

TERM_CTRL -- requirements
Module: term_ctrl

Interface
REQ-001 ck100  input  1  100 MHz system clock; all state changes on its rising edge.
REQ-002 reset  input  1  reset, asynchronous assert, active-low; synchronous release to ck100.
REQ-003 rx_data  input  8  byte from host stream (ASCII plus control codes).
REQ-004 rx_valid  input  1  rx_data valid.
REQ-005 rx_ready  output  1  block accepts rx_data this cycle; transfer = rx_valid && rx_ready.
REQ-006 data  output  8  byte to terminal peripheral data port.
REQ-007 dstrobe  output  1  latch strobe to terminal peripheral; peripheral latches on rising edge.
REQ-008 dtype  output  2  0 = char write, 1 = set column, 2 = set row; 3 never driven.
REQ-009 busy  output  1  high whenever a strobe sequence, clear or ESC parse is in progress.
REQ-010 shrow  output  5  shadow cursor row (0-29); shcol  output  7  shadow cursor column (0-79).

Function
REQ-011 Every peripheral operation SHALL be one 3-cycle strobe cycle: SETUP (data/dtype driven, dstrobe=0), STROBE (dstrobe=1), HOLD (dstrobe=0, data/dtype unchanged).
REQ-012 data and dtype SHALL be stable from SETUP through HOLD; dstrobe SHALL never be high two consecutive cycles.
REQ-013 rx_ready SHALL be 1 only in states IDLE, ESC1, ESCROW, ESCCOL with no strobe cycle pending; 0 otherwise.
REQ-014 Printable byte (0x20-0x7E, 0x80-0xFF) in IDLE SHALL issue one dtype=0 op with data=byte; shadow col+1, at col 79 col->0 and row+1, row 29 wraps to 0.
REQ-015 CR (0x0D) SHALL issue dtype=1 data=0; shcol=0.
REQ-016 LF (0x0A) SHALL issue dtype=2 data=(shrow==29 ? 0 : shrow+1); shcol unchanged.
REQ-017 BS (0x08) SHALL issue dtype=1 data=shcol-1 when shcol>0; at shcol=0 no op, byte consumed.
REQ-018 FF (0x0C) SHALL enter CLEAR: set col 0, set row 0, 2400 dtype=0 ops with data=0x20, then set col 0, set row 0; shadow ends at 0,0; 2404 strobe cycles total.
REQ-019 ESC (0x1B) SHALL go to ESC1; next byte 'Y' (0x59) -> ESCROW, any other byte discarded -> IDLE with no op.
REQ-020 ESCROW captures r=byte-0x20, ESCCOL captures c=byte-0x20; then issue set column c then set row r (two strobe cycles, column first).
REQ-021 ESC coordinates SHALL saturate: r>29 -> 29, c>79 -> 79; bytes <0x20 clamp to 0.
REQ-022 All other bytes (0x00-0x1F not listed, 0x7F) SHALL be consumed in one cycle with no op.
REQ-023 Shadow cursor SHALL update in the HOLD cycle of the op that changes it.
REQ-024 Latency: accepted printable byte -> dstrobe rising edge exactly 2 cycles later (accept, SETUP, STROBE).
REQ-025 busy SHALL equal !rx_ready except in IDLE, where busy=0.

Reset
REQ-026 While reset=0: dstrobe=0, data=0, dtype=0, rx_ready=0, busy=1, shrow=0, shcol=0, parser state IDLE.
REQ-027 After release, block SHALL issue set col 0 then set row 0 (home sequence) before first rx_ready=1.
REQ-028 Reset asserted mid-strobe or mid-CLEAR SHALL force dstrobe=0 immediately; home sequence repeats after release.

Structure
REQ-029 Shared package term_pkg SHALL hold ROWS=30, COLS=80, dtype encodings, control codes (CR, LF, BS, FF, ESC, 'Y'), SPACE=0x20.
REQ-030 Strobe timing SHALL live in sub-module term_strobe (req/op/data in, SETUP/STROBE/HOLD sequencing, done pulse out); term_ctrl holds parser FSM, CLEAR counter (12-bit, 0-2399), shadow cursor.

Verification
REQ-031 Reset release -> ops (dtype1,0x00),(dtype2,0x00), then rx_ready=1; shrow=0, shcol=0.
REQ-032 Send 'A' (0x41) at col 79 row 29 -> one dtype0 op data 0x41, dstrobe rises 2 cycles after accept; shadow -> row 0 col 0.
REQ-033 Send 1B 59 25 3A -> ops (dtype1,0x1A),(dtype2,0x05); shrow=5 shcol=26; 1B 59 7F 7F -> (1,79),(2,29).
REQ-034 Send 0C -> 2404 strobes, exactly 2400 with dtype0 data 0x20, rx_ready low throughout, ends shadow 0,0.
REQ-035 BS at col 0, 0x07, and 1B 41 -> no dstrobe pulses, each byte accepted, state IDLE.
REQ-036 Assert reset during CLEAR op 1000 -> dstrobe=0 same cycle, after release home sequence only, no further char writes.

Source files
------------

// File: rtl/term_pkg.sv
// Shared constants, encodings and helpers for the terminal controller.
// The cursor geometry, peripheral op codes and host control codes are defined here.
package term_pkg;

    localparam int ROWS = 30;
    localparam int COLS = 80;

    localparam logic [4:0]  ROW_MAX  = 5'd29;
    localparam logic [6:0]  COL_MAX  = 7'd79;
    localparam logic [11:0] CLR_LAST = 12'd2399;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_Y     = 8'h59;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        DT_CHAR = 2'd0,
        DT_COL  = 2'd1,
        DT_ROW  = 2'd2
    } dtype_e;

    typedef enum logic [1:0] {
        SB_IDLE   = 2'd0,
        SB_SETUP  = 2'd1,
        SB_STROBE = 2'd2,
        SB_HOLD   = 2'd3
    } sb_state_e;

    typedef enum logic [3:0] {
        CS_START    = 4'd0,
        CS_IDLE     = 4'd1,
        CS_ESC1     = 4'd2,
        CS_ESCROW   = 4'd3,
        CS_ESCCOL   = 4'd4,
        CS_SET_ROW  = 4'd5,
        CS_OP       = 4'd6,
        CS_CLR_COL  = 4'd7,
        CS_CLR_ROW  = 4'd8,
        CS_CLR_CHAR = 4'd9
    } ctrl_state_e;

    // ESC coordinate: offset by 0x20, control bytes clamp to 0, saturate at lim.
    function automatic logic [7:0] coord_clamp(input logic [7:0] b, input logic [7:0] lim);
        logic [7:0] v;
        if (b < CH_SPACE) begin
            v = 8'd0;
        end else begin
            v = b - CH_SPACE;
        end
        if (v > lim) begin
            v = lim;
        end else begin
            v = v;
        end
        return v;
    endfunction

    function automatic logic is_printable(input logic [7:0] b);
        return ((b >= 8'h20) && (b <= 8'h7E)) || (b >= 8'h80);
    endfunction

endpackage

// File: rtl/term_strobe.sv
// Peripheral strobe sequencer: every op is SETUP, STROBE, HOLD with data/dtype frozen.
// A new request is taken in IDLE or in the HOLD cycle, so ops can run back to back.
module term_strobe
    import term_pkg::*;
(
    input  logic       ck100,
    input  logic       i_rst_n,
    input  logic       i_req,
    input  logic [1:0] i_op,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic [1:0] o_dtype,
    output logic       o_dstrobe,
    output logic       o_done
);

    sb_state_e  r_state;
    sb_state_e  w_state_nxt;
    logic [7:0] r_data;
    logic [7:0] w_data_nxt;
    logic [1:0] r_dtype;
    logic [1:0] w_dtype_nxt;
    logic       r_dstrobe;
    logic       w_dstrobe_nxt;
    logic       r_done;
    logic       w_done_nxt;

    // Next-state and next-output decode for the strobe sequence.
    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = r_data;
        w_dtype_nxt   = r_dtype;
        w_dstrobe_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            SB_IDLE, SB_HOLD: begin
                if (i_req) begin
                    w_state_nxt = SB_SETUP;
                    w_data_nxt  = i_data;
                    w_dtype_nxt = i_op;
                end else begin
                    w_state_nxt = SB_IDLE;
                end
            end
            SB_SETUP: begin
                w_state_nxt   = SB_STROBE;
                w_dstrobe_nxt = 1'b1;
            end
            SB_STROBE: begin
                w_state_nxt = SB_HOLD;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = SB_IDLE;
            end
        endcase
    end

    // State and registered peripheral outputs.
    always_ff @(posedge ck100 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= SB_IDLE;
            r_data    <= 8'd0;
            r_dtype   <= 2'd0;
            r_dstrobe <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_data    <= w_data_nxt;
            r_dtype   <= w_dtype_nxt;
            r_dstrobe <= w_dstrobe_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign o_data    = r_data;
    assign o_dtype   = r_dtype;
    assign o_dstrobe = r_dstrobe;
    assign o_done    = r_done;

endmodule

// File: rtl/term_ctrl.sv
// Terminal controller: host byte parser, screen clear sequencer and shadow cursor.
// Peripheral timing is delegated to term_strobe; o_done marks the HOLD cycle of each op.
module term_ctrl
    import term_pkg::*;
(
    input  logic       ck100,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] data,
    output logic       dstrobe,
    output logic [1:0] dtype,
    output logic       busy,
    output logic [4:0] shrow,
    output logic [6:0] shcol
);

    logic [1:0]  r_rst_pipe;
    logic        w_rst_n;
    ctrl_state_e r_state;
    ctrl_state_e w_state_nxt;
    logic [11:0] r_clr_cnt;
    logic [11:0] w_clr_cnt_nxt;
    logic [7:0]  r_row_tgt;
    logic [7:0]  w_row_tgt_nxt;
    logic        r_rx_ready;
    logic        r_busy;
    logic [4:0]  r_shrow;
    logic [6:0]  r_shcol;
    logic        w_accept;
    logic        w_req;
    logic        w_done;
    logic        w_rdy_nxt;
    logic [1:0]  w_op;
    logic [7:0]  w_wdata;
    logic [7:0]  w_row_clamp;
    logic [7:0]  w_col_clamp;
    logic [7:0]  w_lf_row;

    // Reset synchronizer: asserts asynchronously, releases on ck100.
    always_ff @(posedge ck100 or negedge reset) begin
        if (!reset) begin
            r_rst_pipe <= 2'b00;
        end else begin
            r_rst_pipe <= {r_rst_pipe[0], 1'b1};
        end
    end

    assign w_rst_n     = r_rst_pipe[1];
    assign w_accept    = rx_valid && r_rx_ready;
    assign w_row_clamp = coord_clamp(rx_data, {3'b000, ROW_MAX});
    assign w_col_clamp = coord_clamp(rx_data, {1'b0, COL_MAX});
    assign w_lf_row    = (r_shrow == ROW_MAX) ? 8'd0 : {3'b000, r_shrow + 5'd1};
    assign w_rdy_nxt   = (w_state_nxt == CS_IDLE)   || (w_state_nxt == CS_ESC1) ||
                         (w_state_nxt == CS_ESCROW) || (w_state_nxt == CS_ESCCOL);

    // Parser / sequencer next state and strobe requests.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_row_tgt_nxt = r_row_tgt;
        w_req         = 1'b0;
        w_op          = DT_CHAR;
        w_wdata       = 8'd0;
        case (r_state)
            CS_START: begin
                // Home sequence reuses the column-then-row path with target row 0.
                w_req         = 1'b1;
                w_op          = DT_COL;
                w_row_tgt_nxt = 8'd0;
                w_state_nxt   = CS_SET_ROW;
            end
            CS_IDLE: begin
                if (!w_accept) begin
                    w_state_nxt = CS_IDLE;
                end else if (is_printable(rx_data)) begin
                    w_req       = 1'b1;
                    w_op        = DT_CHAR;
                    w_wdata     = rx_data;
                    w_state_nxt = CS_OP;
                end else if (rx_data == CH_CR) begin
                    w_req       = 1'b1;
                    w_op        = DT_COL;
                    w_state_nxt = CS_OP;
                end else if (rx_data == CH_LF) begin
                    w_req       = 1'b1;
                    w_op        = DT_ROW;
                    w_wdata     = w_lf_row;
                    w_state_nxt = CS_OP;
                end else if ((rx_data == CH_BS) && (r_shcol != 7'd0)) begin
                    w_req       = 1'b1;
                    w_op        = DT_COL;
                    w_wdata     = {1'b0, r_shcol - 7'd1};
                    w_state_nxt = CS_OP;
                end else if (rx_data == CH_FF) begin
                    w_req       = 1'b1;
                    w_op        = DT_COL;
                    w_state_nxt = CS_CLR_COL;
                end else if (rx_data == CH_ESC) begin
                    w_state_nxt = CS_ESC1;
                end else begin
                    w_state_nxt = CS_IDLE;
                end
            end
            CS_ESC1: begin
                if (w_accept) begin
                    w_state_nxt = (rx_data == CH_Y) ? CS_ESCROW : CS_IDLE;
                end else begin
                    w_state_nxt = CS_ESC1;
                end
            end
            CS_ESCROW: begin
                if (w_accept) begin
                    w_row_tgt_nxt = w_row_clamp;
                    w_state_nxt   = CS_ESCCOL;
                end else begin
                    w_state_nxt = CS_ESCROW;
                end
            end
            CS_ESCCOL: begin
                if (w_accept) begin
                    w_req       = 1'b1;
                    w_op        = DT_COL;
                    w_wdata     = w_col_clamp;
                    w_state_nxt = CS_SET_ROW;
                end else begin
                    w_state_nxt = CS_ESCCOL;
                end
            end
            CS_SET_ROW: begin
                if (w_done) begin
                    w_req       = 1'b1;
                    w_op        = DT_ROW;
                    w_wdata     = r_row_tgt;
                    w_state_nxt = CS_OP;
                end else begin
                    w_state_nxt = CS_SET_ROW;
                end
            end
            CS_OP: begin
                w_state_nxt = w_done ? CS_IDLE : CS_OP;
            end
            CS_CLR_COL: begin
                if (w_done) begin
                    w_req       = 1'b1;
                    w_op        = DT_ROW;
                    w_state_nxt = CS_CLR_ROW;
                end else begin
                    w_state_nxt = CS_CLR_COL;
                end
            end
            CS_CLR_ROW: begin
                if (w_done) begin
                    w_req         = 1'b1;
                    w_op          = DT_CHAR;
                    w_wdata       = CH_SPACE;
                    w_clr_cnt_nxt = 12'd0;
                    w_state_nxt   = CS_CLR_CHAR;
                end else begin
                    w_state_nxt = CS_CLR_ROW;
                end
            end
            CS_CLR_CHAR: begin
                if (!w_done) begin
                    w_state_nxt = CS_CLR_CHAR;
                end else if (r_clr_cnt == CLR_LAST) begin
                    w_req         = 1'b1;
                    w_op          = DT_COL;
                    w_row_tgt_nxt = 8'd0;
                    w_state_nxt   = CS_SET_ROW;
                end else begin
                    w_req         = 1'b1;
                    w_op          = DT_CHAR;
                    w_wdata       = CH_SPACE;
                    w_clr_cnt_nxt = r_clr_cnt + 12'd1;
                    w_state_nxt   = CS_CLR_CHAR;
                end
            end
            default: begin
                w_state_nxt = CS_START;
            end
        endcase
    end

    // Parser state, clear counter, ESC row capture and handshake outputs.
    always_ff @(posedge ck100 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= CS_START;
            r_clr_cnt  <= 12'd0;
            r_row_tgt  <= 8'd0;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_row_tgt  <= w_row_tgt_nxt;
            r_rx_ready <= w_rdy_nxt;
            r_busy     <= !w_rdy_nxt;
        end
    end

    // Shadow cursor follows the op completing in its HOLD cycle.
    always_ff @(posedge ck100 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_shrow <= 5'd0;
            r_shcol <= 7'd0;
        end else if (w_done) begin
            case (dtype)
                DT_CHAR: begin
                    if (r_shcol == COL_MAX) begin
                        r_shcol <= 7'd0;
                        r_shrow <= (r_shrow == ROW_MAX) ? 5'd0 : r_shrow + 5'd1;
                    end else begin
                        r_shcol <= r_shcol + 7'd1;
                    end
                end
                DT_COL: begin
                    r_shcol <= data[6:0];
                end
                DT_ROW: begin
                    r_shrow <= data[4:0];
                end
                default: begin
                    r_shrow <= r_shrow;
                end
            endcase
        end else begin
            r_shrow <= r_shrow;
            r_shcol <= r_shcol;
        end
    end

    term_strobe u_strobe (
        .ck100     (ck100),
        .i_rst_n   (w_rst_n),
        .i_req     (w_req),
        .i_op      (w_op),
        .i_data    (w_wdata),
        .o_data    (data),
        .o_dtype   (dtype),
        .o_dstrobe (dstrobe),
        .o_done    (w_done)
    );

    assign rx_ready = r_rx_ready;
    assign busy     = r_busy;
    assign shrow    = r_shrow;
    assign shcol    = r_shcol;

endmodule
